// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types: data word, opcode enum, default register count
// Purpose: common definitions for the combinational ALU and the issue/writeback stage.
// Contents: word_t, alu_op_e (code 7 reserved), OP_RSVD, NREGS_DEFAULT, op_writes().
package alu_pkg;

  typedef bit [7:0] word_t;

  typedef enum logic [2:0] {
    OP_NUL = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_XOR = 3'd3,
    OP_MVB = 3'd4,
    OP_MAX = 3'd5,
    OP_MIN = 3'd6
  } alu_op_e;

  localparam logic [2:0] OP_RSVD = 3'd7;
  localparam int NREGS_DEFAULT = 8;

  // OP_NUL and the reserved code flow through the pipe but never write back.
  function automatic logic op_writes(input logic [2:0] op);
    return (op != 3'(OP_NUL)) && (op != OP_RSVD);
  endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// rtl/alu_issue_seq_if.sv - instruction issue handshake bundle
// Purpose: groups the valid/ready instruction channel into one port.
// Signals: in_valid, in_ready, in_op, in_rd, in_ra, in_rb, in_imm_en, in_imm.
// Modports: master (instruction source), slave (alu_issue_seq).
interface alu_issue_seq_if
  import alu_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT
);
  localparam int ADDR_W = $clog2(NREGS);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [ADDR_W-1:0] in_rd;
  logic [ADDR_W-1:0] in_ra;
  logic [ADDR_W-1:0] in_rb;
  logic              in_imm_en;
  word_t             in_imm;

  modport master (
    output in_valid, in_op, in_rd, in_ra, in_rb, in_imm_en, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_ra, in_rb, in_imm_en, in_imm,
    output in_ready
  );

endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREGS x 8 register file, two async read ports, one sync write port
// Purpose: architectural registers of the issue stage; cleared by rst_n.
// Ports: clk, rst_n (async active-low clear), i_ra/o_rd_a and i_rb/o_rd_b (read ports),
//        i_we/i_waddr/i_wdata (write port, rising edge).
module alu_regfile
  import alu_pkg::*;
#(
  parameter  int NREGS  = NREGS_DEFAULT,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_ra,
  input  logic [ADDR_W-1:0] i_rb,
  output word_t             o_rd_a,
  output word_t             o_rd_b,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  word_t             i_wdata
);

  word_t r_regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rd_a = r_regs[i_ra];
  assign o_rd_b = r_regs[i_rb];

endmodule

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - issue/writeback stage in front of the combinational 8-bit ALU
// Purpose: accepts one instruction at a time, drives the ALU for one cycle, writes the
//          result back to the register file and records the ALU flag.
// Ports: clk, rst_n (async active-low); s_in (instruction handshake, slave modport);
//        alu_a/alu_b/alu_op/alu_start to the ALU, alu_o/alu_flag from it;
//        wb_valid/wb_addr/wb_data writeback pulse; flag_q last written flag; busy.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter  int NREGS  = NREGS_DEFAULT,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_seq_if.slave    s_in,
  output word_t             alu_a,
  output word_t             alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_start,
  input  word_t             alu_o,
  input  logic              alu_flag,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output word_t             wb_data,
  output logic              flag_q,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_e;

  state_e            r_state;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_rd;
  logic              r_flg;
  word_t             r_alu_a;
  word_t             r_alu_b;
  logic [2:0]        r_alu_op;
  logic              r_alu_start;
  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_addr;
  word_t             r_wb_data;
  logic              r_flag_q;

  word_t w_rd_a;
  word_t w_rd_b;
  logic  w_accept;

  assign w_accept = s_in.in_valid && s_in.in_ready;

  // Register ports look straight at the offered operand addresses: the operands are
  // fetched on the accept edge. Nothing can write the file between accept and EXEC,
  // so this yields the same values as a read in EXEC while keeping the ALU inputs registered.
  alu_regfile #(.NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_ra    (s_in.in_ra),
    .i_rb    (s_in.in_rb),
    .o_rd_a  (w_rd_a),
    .o_rd_b  (w_rd_b),
    .i_we    (r_wb_valid),
    .i_waddr (r_wb_addr),
    .i_wdata (r_wb_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= 3'(OP_NUL);
      r_rd        <= '0;
      r_flg       <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= 3'(OP_NUL);
      r_alu_start <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_flag_q    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op        <= s_in.in_op;
            r_rd        <= s_in.in_rd;
            r_alu_a     <= w_rd_a;
            r_alu_b     <= s_in.in_imm_en ? s_in.in_imm : w_rd_b;
            r_alu_op    <= s_in.in_op;
            r_alu_start <= 1'b1;
            r_state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_wb_data   <= alu_o;
          r_flg       <= alu_flag;
          r_wb_addr   <= r_rd;
          r_wb_valid  <= op_writes(r_op);
          // Return the ALU to idle inputs as soon as its single cycle is over.
          r_alu_a     <= '0;
          r_alu_b     <= '0;
          r_alu_op    <= 3'(OP_NUL);
          r_alu_start <= 1'b0;
          r_state     <= ST_WB;
        end
        ST_WB: begin
          // r_wb_valid doubles as the register file write enable for this edge.
          if (r_wb_valid) begin
            r_flag_q <= r_flg;
          end
          r_wb_valid <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Gated by rst_n so the source sees not-ready for the whole reset interval.
  assign s_in.in_ready = (r_state == ST_IDLE) && rst_n;
  assign busy          = (r_state != ST_IDLE);
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_op        = r_alu_op;
  assign alu_start     = r_alu_start;
  assign wb_valid      = r_wb_valid;
  assign wb_addr       = r_wb_addr;
  assign wb_data       = r_wb_data;
  assign flag_q        = r_flag_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - self-checking bench for alu_issue_seq with a reference ALU
module tb_alu_issue_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_seq_if #(.NREGS(8)) bus ();

  logic [7:0] alu_a, alu_b, alu_o, wb_data;
  logic [2:0] alu_op, wb_addr;
  logic       alu_start, alu_flag, wb_valid, flag_q, busy;

  alu_issue_seq #(.NREGS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_in      (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_start (alu_start),
    .alu_o     (alu_o),
    .alu_flag  (alu_flag),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .flag_q    (flag_q),
    .busy      (busy)
  );

  // Reference ALU: {flag, result}
  function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    case (op)
      3'd1: s = {1'b0, a} + {1'b0, b};
      3'd2: s = {(a < b), 8'(a - b)};
      3'd3: s = {((a ^ b) == 8'h00), a ^ b};
      3'd4: s = {(b != 8'h00), b};
      3'd5: s = {(a < b), ((a > b) ? a : b)};
      3'd6: s = {(a < b), ((a < b) ? a : b)};
      default: s = 9'h000;
    endcase
    return s;
  endfunction

  assign {alu_flag, alu_o} = alu_ref(alu_op, alu_a, alu_b);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: architectural registers plus the one instruction in flight,
  // scheduled by the accept edge (EXEC at acc, WB at acc+1, retired at acc+2).
  logic [7:0] m_regs [8];
  logic       m_flag;
  bit         p_vld;
  int         p_acc;
  logic [2:0] p_op, p_rd;
  logic [7:0] p_a, p_b, p_res;
  logic       p_flg;
  int         wb_count = 0;
  logic [2:0] last_wb_addr;
  logic [7:0] last_wb_data;
  logic       e_start, e_wb, p_writes;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_flag = 1'b0;
      p_vld  = 1'b0;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_alu_start", alu_start, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_flag_q", flag_q, 0);
    end else begin
      p_writes = (p_op != 3'd0) && (p_op != 3'd7);
      if (p_vld && cyc == p_acc + 2) begin
        if (p_writes) begin
          m_regs[p_rd] = p_res;
          m_flag = p_flg;
        end
        p_vld = 1'b0;
      end
      e_start = p_vld && (cyc == p_acc);
      e_wb    = p_vld && (cyc == p_acc + 1) && p_writes;
      chk("busy", busy, p_vld);
      chk("in_ready", bus.in_ready, !p_vld);
      chk("alu_start", alu_start, e_start);
      chk("wb_valid", wb_valid, e_wb);
      chk("flag_q", flag_q, m_flag);
      if (e_start) begin
        chk("alu_a", alu_a, p_a);
        chk("alu_b", alu_b, p_b);
        chk("alu_op", alu_op, p_op);
      end else begin
        chk("alu_a_idle", alu_a, 0);
        chk("alu_b_idle", alu_b, 0);
        chk("alu_op_idle", alu_op, 0);
      end
      if (e_wb) begin
        chk("wb_addr", wb_addr, p_rd);
        chk("wb_data", wb_data, p_res);
      end
      if (wb_valid) begin
        wb_count++;
        last_wb_addr = wb_addr;
        last_wb_data = wb_data;
      end
      if (bus.in_valid && bus.in_ready) begin
        p_vld = 1'b1;
        p_acc = cyc + 1;
        p_op  = bus.in_op;
        p_rd  = bus.in_rd;
        p_a   = m_regs[bus.in_ra];
        p_b   = bus.in_imm_en ? bus.in_imm : m_regs[bus.in_rb];
        {p_flg, p_res} = alu_ref(p_op, p_a, p_b);
      end
    end
  end

  task automatic offer(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic ie, input logic [7:0] imm);
    bus.in_op = op; bus.in_rd = rd; bus.in_ra = ra; bus.in_rb = rb;
    bus.in_imm_en = ie; bus.in_imm = imm; bus.in_valid = 1'b1;
  endtask

  task automatic wait_ready(input string nm);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.in_ready && t < 20);
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept in_ready=0 after %0d cycles, required 1", nm, t);
    end
  endtask

  // Issue one instruction, scramble the fields right after acceptance, then check
  // the hand-computed writeback and flag once the stage is idle again.
  task automatic issue(input string nm, input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] ra, input logic [2:0] rb, input logic ie,
                       input logic [7:0] imm, input bit exp_wb, input logic [7:0] exp_data,
                       input logic exp_flag);
    int c0;
    offer(op, rd, ra, rb, ie, imm);
    wait_ready(nm);
    c0 = wb_count;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    offer(3'd1, ~rd, ~ra, ~rb, ~ie, ~imm);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_wbcount"}, wb_count, c0 + (exp_wb ? 1 : 0));
    if (exp_wb) begin
      chk({nm, "_addr"}, last_wb_addr, rd);
      chk({nm, "_data"}, last_wb_data, exp_data);
    end
    chk({nm, "_flag"}, flag_q, exp_flag);
  endtask

  int accs [4];
  logic [7:0] b2b_imm [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int c_rst;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required to finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    offer(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.in_ready, 1);
    chk("post_rst_busy", busy, 0);

    issue("mvb_r1", OP_MVB, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 1, 8'h05, 1'b1);
    issue("mvb_r2", OP_MVB, 3'd2, 3'd0, 3'd0, 1'b1, 8'hFF, 1, 8'hFF, 1'b1);
    issue("add_r3", OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 1, 8'h04, 1'b1);
    issue("sub_r4", OP_SUB, 3'd4, 3'd1, 3'd1, 1'b0, 8'h00, 1, 8'h00, 1'b0);
    issue("xor_r5", OP_XOR, 3'd5, 3'd2, 3'd2, 1'b0, 8'h00, 1, 8'h00, 1'b1);
    issue("min_r6", OP_MIN, 3'd6, 3'd1, 3'd2, 1'b0, 8'h00, 1, 8'h05, 1'b1);
    issue("max_r7", OP_MAX, 3'd7, 3'd1, 3'd1, 1'b0, 8'h00, 1, 8'h05, 1'b0);
    issue("nul_r1", OP_NUL, 3'd1, 3'd2, 3'd2, 1'b0, 8'h00, 0, 8'h00, 1'b0);
    issue("rsv_r1", 3'd7, 3'd1, 3'd2, 3'd2, 1'b1, 8'hFF, 0, 8'h00, 1'b0);
    issue("r1_kept", OP_ADD, 3'd1, 3'd1, 3'd0, 1'b1, 8'h00, 1, 8'h05, 1'b0);
    issue("sub_wrap", OP_SUB, 3'd0, 3'd0, 3'd0, 1'b1, 8'h01, 1, 8'hFF, 1'b1);

    // in_valid held high: fields for the next instruction change during EXEC
    for (int k = 0; k < 4; k++) begin
      offer(OP_MVB, 3'(k + 2), 3'd0, 3'd0, 1'b1, b2b_imm[k]);
      wait_ready("b2b");
      accs[k] = cyc;
      @(posedge clk); #1;
      bus.in_imm = 8'hA5;
    end
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 1; k < 4; k++) chk("b2b_spacing", accs[k] - accs[k-1], 3);
    issue("b2b_r3", OP_ADD, 3'd6, 3'd3, 3'd0, 1'b1, 8'h00, 1, 8'h22, 1'b0);
    issue("b2b_r5", OP_ADD, 3'd7, 3'd5, 3'd0, 1'b1, 8'h00, 1, 8'h44, 1'b0);

    // reset in the middle of EXEC of ADD r3 = r1 + r2
    offer(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00);
    wait_ready("rst_add");
    c_rst = wb_count;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_wbcount", wb_count, c_rst);
    chk("abort_busy", busy, 0);
    chk("abort_ready", bus.in_ready, 1);
    chk("abort_flag", flag_q, 0);
    issue("abort_r3", OP_ADD, 3'd3, 3'd3, 3'd0, 1'b1, 8'h00, 1, 8'h00, 1'b0);
    issue("after_rst", OP_MVB, 3'd1, 3'd0, 3'd0, 1'b1, 8'h07, 1, 8'h07, 1'b1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
